// File: rtl/apb_pkg.sv
// Shared APB definitions for the master and the memory slave.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 21;
    localparam int APB_SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } apb_slv_state_e;

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter that paces the PREADY-low wait cycles.
module apb_wait_counter (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    // Zero flag tells the FSM the wait period is over.
    always_comb begin
        zero = (count == '0);
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave: DEPTH words of storage with a programmable wait period.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int SEL_BIT     = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [APB_SEL_W-1:0]  PSEL,
    input  logic                  PENABLE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic                  PREADY,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    apb_slv_state_e        state, state_d;
    logic [APB_ADDR_W-1:0] addr_q;
    logic                  write_q;
    logic                  capture;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic                  sel;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [APB_DATA_W-1:0] mem [DEPTH];

    assign sel      = PSEL[SEL_BIT];
    assign in_range = ({1'b0, addr_q} < (APB_ADDR_W + 1)'(DEPTH));
    assign idx      = addr_q[IDX_W-1:0];

    apb_wait_counter u_wait_counter (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; losing PSEL in WAIT or READY abandons the transfer.
    always_comb begin
        state_d  = state;
        capture  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sel && !PENABLE) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d  = ST_WAIT;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_READY;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address and direction are latched at setup and held for the transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
        end else if (capture) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
        end
    end

    // Storage array; writes commit at the edge ending READY if still selected.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == ST_READY) && sel && write_q && in_range) begin
            mem[idx] <= PWDATA;
        end
    end

    // Response outputs depend on registered state only.
    always_comb begin
        PREADY  = (state == ST_READY);
        PSLVERR = PREADY && !in_range;
        PRDATA  = (PREADY && !write_q && in_range) ? mem[idx] : '0;
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench: two slaves (WAIT_CYCLES=2 and 0) against a word-array model.
module tb_apb_mem_slave;

    localparam int DEPTH = 16;

    logic        PCLK = 1'b0;
    logic        preset  [2];
    logic [2:0]  psel    [2];
    logic        penable [2];
    logic [7:0]  paddr   [2];
    logic        pwrite  [2];
    logic [20:0] pwdata  [2];
    logic        pready  [2];
    logic [20:0] prdata  [2];
    logic        pslverr [2];

    int unsigned wait_of [2] = '{2, 0};
    logic [20:0] model [2][DEPTH];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(2), .SEL_BIT(1)) u_w2 (
        .PCLK(PCLK), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(0), .SEL_BIT(1)) u_w0 (
        .PCLK(PCLK), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ends a transfer: bus goes idle, PREADY must already be low again.
    task automatic release_bus(input int d, input string tag);
        @(negedge PCLK);
        psel[d]    = 3'b000;
        penable[d] = 1'b0;
        check({tag, " pready one cycle"}, 32'(pready[d]), 32'd0);
    endtask

    // Full transfer; returns at the sampling point of the READY cycle, bus still held.
    task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                        input logic [20:0] wd, input string tag);
        int          acc;
        bit          done;
        bit          exp_err;
        logic [20:0] exp_rd;
        exp_err = (addr >= 8'(DEPTH));
        exp_rd  = (!wr && !exp_err) ? model[d][addr[3:0]] : 21'd0;
        @(negedge PCLK);
        psel[d]    = 3'b010;
        penable[d] = 1'b0;
        paddr[d]   = addr;
        pwrite[d]  = wr;
        pwdata[d]  = wd;
        acc  = 0;
        done = 1'b0;
        while (!done && acc < 40) begin
            @(negedge PCLK);
            penable[d] = 1'b1;
            paddr[d]   = 8'($urandom);
            if (pready[d]) begin
                done = 1'b1;
                check({tag, " latency"}, 32'(acc), 32'(wait_of[d]));
                check({tag, " prdata"}, 32'(prdata[d]), 32'(exp_rd));
                check({tag, " pslverr"}, 32'(pslverr[d]), 32'(exp_err));
            end else begin
                check({tag, " quiet outputs"}, {31'd0, pslverr[d]} | 32'(prdata[d]), 32'd0);
                acc++;
            end
        end
        check({tag, " ready seen"}, 32'(done), 32'd1);
        if (done && wr && !exp_err) model[d][addr[3:0]] = wd;
    endtask

    task automatic scan(input int d, input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            xfer(d, 1'b0, 8'(a), 21'd0, tag);
        end
        release_bus(d, tag);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            preset[d]  = 1'b1;
            psel[d]    = 3'b000;
            penable[d] = 1'b0;
            paddr[d]   = '0;
            pwrite[d]  = 1'b0;
            pwdata[d]  = '0;
            for (int a = 0; a < DEPTH; a++) model[d][a] = '0;
        end
        repeat (3) @(negedge PCLK);
        for (int d = 0; d < 2; d++) begin
            check("reset pready", 32'(pready[d]), 32'd0);
            check("reset prdata", 32'(prdata[d]), 32'd0);
            check("reset pslverr", 32'(pslverr[d]), 32'd0);
            preset[d] = 1'b0;
        end

        // Basic write/read with waits and with zero wait.
        xfer(0, 1'b1, 8'd3, 21'h1ABCD, "w2 wr3");
        release_bus(0, "w2 wr3");
        xfer(0, 1'b0, 8'd3, 21'd0, "w2 rd3");
        check("w2 rd3 value", 32'(prdata[0]), 32'h1ABCD);
        release_bus(0, "w2 rd3");
        xfer(1, 1'b1, 8'd0, 21'h00055, "w0 wr0");
        release_bus(1, "w0 wr0");
        xfer(1, 1'b0, 8'd0, 21'd0, "w0 rd0");
        check("w0 rd0 value", 32'(prdata[1]), 32'h00055);
        release_bus(1, "w0 rd0");

        // Out-of-range address on both slaves, then confirm storage intact.
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 8'h20, 21'h12345, "oor wr");
            release_bus(d, "oor wr");
            xfer(d, 1'b0, 8'h20, 21'd0, "oor rd");
            release_bus(d, "oor rd");
            scan(d, "scan after oor");
        end

        // PSEL dropped in the first ACCESS cycle aborts the write.
        for (int d = 0; d < 2; d++) begin
            @(negedge PCLK);
            psel[d] = 3'b010; penable[d] = 1'b0; paddr[d] = 8'd5;
            pwrite[d] = 1'b1; pwdata[d] = 21'h0F0F0;
            @(negedge PCLK);
            psel[d] = 3'b000; penable[d] = 1'b0;
            @(negedge PCLK);
            check("abort pready", 32'(pready[d]), 32'd0);
            xfer(d, 1'b0, 8'd5, 21'd0, "abort rd5");
            check("abort rd5 value", 32'(prdata[d]), 32'd0);
            release_bus(d, "abort rd5");
        end

        // Back-to-back writes with no dead cycle, then readback.
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 8'd1, 21'h0AAAA + 21'(d), "b2b wr1");
            xfer(d, 1'b1, 8'd2, 21'h15555 + 21'(d), "b2b wr2");
            xfer(d, 1'b0, 8'd1, 21'd0, "b2b rd1");
            xfer(d, 1'b0, 8'd2, 21'd0, "b2b rd2");
            release_bus(d, "b2b");
        end

        // PENABLE without a setup phase must not start a transfer.
        for (int d = 0; d < 2; d++) begin
            @(negedge PCLK);
            psel[d] = 3'b010; penable[d] = 1'b1; paddr[d] = 8'd1; pwrite[d] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge PCLK);
                check("penable in idle", 32'(pready[d]), 32'd0);
            end
            psel[d] = 3'b000; penable[d] = 1'b0;
        end

        // Randomized traffic including out-of-range addresses and gaps.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                xfer(d, 1'($urandom), 8'($urandom_range(0, 19)), 21'($urandom), "rand");
                if ($urandom_range(0, 1) == 1) release_bus(d, "rand");
            end
            release_bus(d, "rand end");
            scan(d, "scan after rand");
        end

        // Reset in the middle of a waited write clears everything.
        xfer(0, 1'b1, 8'd7, 21'h1F00F, "pre-reset wr7");
        release_bus(0, "pre-reset wr7");
        @(negedge PCLK);
        psel[0] = 3'b010; penable[0] = 1'b0; paddr[0] = 8'd7;
        pwrite[0] = 1'b1; pwdata[0] = 21'h0BEEF;
        @(negedge PCLK);
        penable[0] = 1'b1; preset[0] = 1'b1; psel[0] = 3'b000;
        @(negedge PCLK);
        preset[0] = 1'b0; penable[0] = 1'b0;
        check("after reset pready", 32'(pready[0]), 32'd0);
        for (int a = 0; a < DEPTH; a++) model[0][a] = '0;
        xfer(0, 1'b0, 8'd7, 21'd0, "post-reset rd7");
        check("post-reset rd7 value", 32'(prdata[0]), 32'd0);
        release_bus(0, "post-reset rd7");
        scan(0, "scan after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
